// File: rtl/data_change_queue_pkg.sv
// Shared helpers for data_change_queue: width calculations used to size the
// channel index, queue pointers and occupancy counter.
package data_change_queue_pkg;

    // Ceiling log2 for elaboration-time sizing (clog2_f(1) == 0).
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Channel index width; a single channel still needs one bit.
    function automatic int ch_bits_f(input int channels);
        return (clog2_f(channels) < 1) ? 1 : clog2_f(channels);
    endfunction

    // Occupancy width: must represent 0..DEPTH inclusive.
    function automatic int level_bits_f(input int depth);
        return clog2_f(depth) + 1;
    endfunction

endpackage

// File: rtl/data_change_queue_rr_arbiter.sv
// Combinational round-robin pick: the first requesting channel after ptr,
// wrapping around, so the last granted channel gets the lowest priority.
module rr_arbiter
    import data_change_queue_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_BITS = ch_bits_f(N)
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [N-1:0]        grant_onehot,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic                grant_valid
);

    // Scan N candidates starting at ptr+1; the first hit locks the grant.
    always_comb begin : pick
        int  cand_s;
        logic hit_s;
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        cand_s       = 0;
        hit_s        = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand_s       = (int'(ptr) + i) % N;
            hit_s        = !grant_valid && req[cand_s];
            grant_idx    = hit_s ? IDX_BITS'(cand_s) : grant_idx;
            grant_onehot = hit_s ? (N'(1) << cand_s) : grant_onehot;
            grant_valid  = grant_valid || hit_s;
        end
    end

endmodule

// File: rtl/data_change_queue.sv
// data_change_queue: watches CHANNELS status words, remembers which changed
// and serialises the newest value of each changed channel into a DEPTH-entry
// first-word-fall-through {channel, data} queue. Changes are coalesced per
// channel, so the queue cannot overflow.
// Optional build macro: DATA_CHANGE_QUEUE_INITIAL_SYNC_EN -- on the first edge
// after reset every channel is marked pending so its current value is emitted.
module data_change_queue
    import data_change_queue_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8,
    localparam int CH_BITS  = ch_bits_f(CHANNELS),
    localparam int LVL_BITS = level_bits_f(DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] dataIn,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [CH_BITS-1:0]        outChannel,
    output logic [WIDTH-1:0]          outData,
    output logic [CHANNELS-1:0]       pendingMask,
    output logic [LVL_BITS-1:0]       level
);

    localparam int PTR_BITS = clog2_f(DEPTH);

    typedef struct packed {
        logic [CH_BITS-1:0] channel;
        logic [WIDTH-1:0]   data;
    } entry_t;

    logic [CHANNELS*WIDTH-1:0] data_in_r;
    logic [CHANNELS-1:0]       pending_r;
    logic [CHANNELS-1:0]       pending_next_s;
    logic [CHANNELS-1:0]       chg_s;
    logic [CH_BITS-1:0]        rr_ptr_r;
    logic [LVL_BITS-1:0]       level_r;
    logic [LVL_BITS-1:0]       level_next_s;
    logic [LVL_BITS-1:0]       remain_s;
    logic [PTR_BITS-1:0]       wr_ptr_r;
    logic [PTR_BITS-1:0]       rd_ptr_r;
    logic [PTR_BITS-1:0]       rd_ptr_next_s;
    entry_t                    mem_r [DEPTH];
    entry_t                    head_r;
    entry_t                    head_next_s;
    entry_t                    push_entry_s;
    logic                      out_valid_r;
    logic [CHANNELS-1:0]       grant_onehot_s;
    logic [CH_BITS-1:0]        grant_idx_s;
    logic                      grant_valid_s;
    logic                      push_s;
    logic                      pop_s;

    // Per-channel change detect against the previous sample.
    always_comb begin
        chg_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            chg_s[c] = (dataIn[c*WIDTH +: WIDTH] != data_in_r[c*WIDTH +: WIDTH]);
        end
    end

    rr_arbiter #(
        .N(CHANNELS)
    ) u_arb (
        .req         (pending_r),
        .ptr         (rr_ptr_r),
        .grant_onehot(grant_onehot_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // No push while full, even if the head is popped on the same edge.
    assign push_s = grant_valid_s && (level_r != LVL_BITS'(DEPTH));
    assign pop_s  = out_valid_r && outReady;

    // The granted channel's value as sampled before this edge.
    always_comb begin
        push_entry_s.channel = grant_idx_s;
        push_entry_s.data    = data_in_r[int'(grant_idx_s)*WIDTH +: WIDTH];
    end

`ifdef DATA_CHANGE_QUEUE_INITIAL_SYNC_EN
    logic primed_r;

    // One-shot flag marking that the post-reset snapshot has been taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            primed_r <= 1'b0;
        end else begin
            primed_r <= 1'b1;
        end
    end

    // Pending update; the first edge after reset marks every channel.
    always_comb begin
        pending_next_s = (pending_r & ~(push_s ? grant_onehot_s : '0)) | chg_s;
        if (!primed_r) begin
            pending_next_s = '1;
        end else begin
            pending_next_s = pending_next_s;
        end
    end
`else
    // Pending update: a change on the grant edge wins over the clear.
    always_comb begin
        pending_next_s = (pending_r & ~(push_s ? grant_onehot_s : '0)) | chg_s;
    end
`endif

    // Next occupancy, read pointer and the head entry shown after the edge.
    always_comb begin
        level_next_s  = level_r;
        rd_ptr_next_s = rd_ptr_r;
        remain_s      = level_r;
        head_next_s   = head_r;
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_BITS'(1);
            remain_s      = level_r - LVL_BITS'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
            remain_s      = level_r;
        end
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_BITS'(1);
            2'b01:   level_next_s = level_r - LVL_BITS'(1);
            default: level_next_s = level_r;
        endcase
        // Surviving entries never share a slot with the one being written.
        if (remain_s != LVL_BITS'(0)) begin
            head_next_s = mem_r[rd_ptr_next_s];
        end else if (push_s) begin
            head_next_s = push_entry_s;
        end else begin
            head_next_s = head_r;
        end
    end

    // Sample register, pending bits, arbiter pointer and queue state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_in_r   <= '0;
            pending_r   <= '0;
            rr_ptr_r    <= CH_BITS'(CHANNELS - 1);
            level_r     <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            head_r      <= '0;
            out_valid_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            data_in_r   <= dataIn;
            pending_r   <= pending_next_s;
            level_r     <= level_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            head_r      <= head_next_s;
            out_valid_r <= (level_next_s != LVL_BITS'(0));
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_BITS'(1);
                rr_ptr_r        <= grant_idx_s;
            end
        end
    end

    assign outValid    = out_valid_r;
    assign outChannel  = head_r.channel;
    assign outData     = head_r.data;
    assign pendingMask = pending_r;
    assign level       = level_r;

endmodule

// File: tb/tb_data_change_queue.sv
// Self-checking bench for data_change_queue: directed scenarios plus random
// traffic, compared every cycle against a queue-based behavioural model.
module tb_data_change_queue;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 8;

    logic                      clock;
    logic                      reset;
    logic [CHANNELS*WIDTH-1:0] dataIn;
    logic                      outValid;
    logic                      outReady;
    logic [1:0]                outChannel;
    logic [WIDTH-1:0]          outData;
    logic [CHANNELS-1:0]       pendingMask;
    logic [3:0]                level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ch;
        int data;
    } ent_t;

    ent_t mq[$];
    int   mprev [CHANNELS];
    bit   mpend [CHANNELS];
    int   mlast;
    bit   mprimed;
    int   cur   [CHANNELS];

    data_change_queue #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .dataIn(dataIn),
        .outValid(outValid), .outReady(outReady),
        .outChannel(outChannel), .outData(outData),
        .pendingMask(pendingMask), .level(level)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int c = 0; c < CHANNELS; c++) begin
            mprev[c] = 0;
            mpend[c] = 1'b0;
        end
        mlast   = CHANNELS - 1;
        mprimed = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using pre-edge state.
    task automatic model_edge();
        int sz;
        int g;
        sz = mq.size();
        g  = -1;
        if (sz > 0 && outReady) void'(mq.pop_front());
`ifdef DATA_CHANGE_QUEUE_INITIAL_SYNC_EN
        if (!mprimed) begin
            for (int c = 0; c < CHANNELS; c++) begin
                mprev[c] = cur[c];
                mpend[c] = 1'b1;
            end
            mprimed = 1'b1;
            return;
        end
`endif
        if (sz < DEPTH) begin
            for (int i = 1; i <= CHANNELS; i++) begin
                int c;
                c = (mlast + i) % CHANNELS;
                if (g < 0 && mpend[c]) g = c;
            end
        end
        if (g >= 0) begin
            mq.push_back('{g, mprev[g]});
            mpend[g] = 1'b0;
            mlast    = g;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (cur[c] != mprev[c]) mpend[c] = 1'b1;
            mprev[c] = cur[c];
        end
    endtask

    task automatic compare();
        logic [31:0] m;
        m = 0;
        for (int c = 0; c < CHANNELS; c++) m[c] = mpend[c];
        check("outValid", outValid, (mq.size() > 0) ? 1 : 0);
        check("level", level, mq.size());
        check("pendingMask", pendingMask, m);
        if (mq.size() > 0) begin
            check("outChannel", outChannel, mq[0].ch);
            check("outData", outData, mq[0].data);
        end
    endtask

    task automatic step(input bit ready);
        for (int c = 0; c < CHANNELS; c++) dataIn[c*WIDTH +: WIDTH] = cur[c][WIDTH-1:0];
        outReady = ready;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #2;
        check("rst_outValid", outValid, 0);
        check("rst_level", level, 0);
        check("rst_pending", pendingMask, 0);
        check("rst_outChannel", outChannel, 0);
        check("rst_outData", outData, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 24; i++) step(1'b1);
    endtask

    initial begin
        clock    = 1'b0;
        reset    = 1'b1;
        dataIn   = '0;
        outReady = 1'b0;
        for (int c = 0; c < CHANNELS; c++) cur[c] = 0;
        @(negedge clock);
        do_reset();

`ifdef DATA_CHANGE_QUEUE_INITIAL_SYNC_EN
        // Priming: zero values are emitted once per channel; then drain them.
        drain();
`else
        // Idle with all-zero input produces nothing.
        step(1'b0);
        step(1'b0);
        check("idle_level", level, 0);
`endif

        // Single change on channel 2 is visible one edge after detection.
        cur[2] = 8'h5A;
        step(1'b0);
        step(1'b0);
        check("t1_valid", outValid, 1);
        check("t1_channel", outChannel, 2);
        check("t1_data", outData, 8'h5A);
        check("t1_level", level, 1);
        drain();

        // Three channels changing together are queued in round-robin order.
        cur[0] = 8'h10; cur[1] = 8'h11; cur[3] = 8'h13;
        for (int i = 0; i < 5; i++) step(1'b0);
        drain();

        // Fill the queue and keep changing channel 0 while it is full.
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < CHANNELS; c++) cur[c] = (cur[c] + 1 + c) & 8'hFF;
            step(1'b0);
        end
        check("full_level", level, DEPTH);
        for (int i = 0; i < 3; i++) begin
            cur[0] = (cur[0] + 7) & 8'hFF;
            step(1'b0);
        end
        check("full_pend0", pendingMask[0], 1);
        step(1'b1);
        step(1'b0);
        check("refill_level", level, DEPTH);
        drain();

        // Coalescing: channel 1 changes repeatedly while blocked.
        for (int i = 0; i < 10; i++) begin
            cur[2] = (cur[2] + 3) & 8'hFF;
            cur[3] = (cur[3] + 5) & 8'hFF;
            step(1'b0);
        end
        for (int v = 1; v <= 4; v++) begin
            cur[1] = v;
            step(1'b0);
        end
        drain();

        // Channel 3 changes on the very edge it is granted.
        cur[3] = 8'hA0;
        step(1'b0);
        cur[3] = 8'hA1;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        drain();

        // Random traffic with a reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if ($urandom_range(0, 5) == 0) cur[c] = $urandom_range(0, 255);
            end
            if (i == 700) begin
                do_reset();
            end
            step((i % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
